// File: rtl/x_400_mod_4051_lift_pkg.sv
// Shared widths, constants and FSM encoding for the 400-bit mod-4051 lift
// (rebuilds X = Q*4051 + R one 12-bit digit at a time).
package mod_4051_pkg;

  localparam int MODULUS  = 4051;
  localparam int DIGIT_W  = 12;
  localparam int N_DIGITS = 34;
  localparam int X_W      = 400;

  typedef logic [DIGIT_W-1:0] digit_t;
  typedef logic [5:0]         cnt_t;

  localparam digit_t MODULUS_D = digit_t'(MODULUS);
  localparam cnt_t   LAST_IDX  = cnt_t'(N_DIGITS - 1);
  // Bits of the top digit that lie above X_W and must be zero for a legal X.
  localparam int     SPARE_W   = N_DIGITS * DIGIT_W - X_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_e;

endpackage

// File: rtl/x_400_mod_4051_lift_if.sv
// Digit-stream interface of the mod-4051 lift; err exists only when
// X400_MOD_4051_CHECK_EN is defined.
interface x_400_mod_4051_lift_if;
  import mod_4051_pkg::*;

  logic   start;
  digit_t r_in;
  logic   q_valid;
  logic   q_ready;
  digit_t q_digit;
  logic   x_valid;
  logic   x_ready;
  digit_t x_digit;
  logic   x_last;
  logic   busy;
  logic   done;
`ifdef X400_MOD_4051_CHECK_EN
  logic   err;
`endif

  modport slave (
    input  start, r_in, q_valid, q_digit, x_ready,
    output q_ready, x_valid, x_digit, x_last, busy, done
`ifdef X400_MOD_4051_CHECK_EN
    , output err
`endif
  );

  modport master (
    output start, r_in, q_valid, q_digit, x_ready,
    input  q_ready, x_valid, x_digit, x_last, busy, done
`ifdef X400_MOD_4051_CHECK_EN
    , input err
`endif
  );

endinterface

// File: rtl/x_400_mod_4051_lift_mac.sv
// One digit step of the lift: {carry_o, digit_o} = q_i*4051 + c_i.
// The product plus carry always fits in two digits.
module mod_4051_digit_mac
  import mod_4051_pkg::*;
(
  input  digit_t q_i,
  input  digit_t c_i,
  output digit_t digit_o,
  output digit_t carry_o
);

  localparam int P_W = 2 * DIGIT_W;

  logic [P_W-1:0] p;

  assign p = P_W'(q_i) * P_W'(MODULUS) + P_W'(c_i);
  assign {carry_o, digit_o} = p;

endmodule

// File: rtl/x_400_mod_4051_lift.sv
// Digit-serial X = Q*4051 + R reconstruction with a single-entry output register.
// Optional range checking (err port) under X400_MOD_4051_CHECK_EN.
module x_400_mod_4051_lift
  import mod_4051_pkg::*;
(
  input logic                   clk,
  input logic                   rst_n,
  x_400_mod_4051_lift_if.slave  bus
);

  state_e state_q, state_d;
  digit_t carry_q, carry_d;
  cnt_t   cnt_q, cnt_d;
  digit_t x_digit_q, x_digit_d;
  logic   x_valid_q, x_valid_d;
  logic   x_last_q, x_last_d;
  logic   done_q, done_d;
`ifdef X400_MOD_4051_CHECK_EN
  logic   err_q, err_d;
`endif

  logic   q_ready;
  logic   q_accept;
  logic   x_take;
  digit_t mac_digit;
  digit_t mac_carry;

  mod_4051_digit_mac u_mac (
    .q_i     (bus.q_digit),
    .c_i     (carry_q),
    .digit_o (mac_digit),
    .carry_o (mac_carry)
  );

  // No skid buffer: a new digit is taken only if the output slot frees this cycle.
  assign q_ready  = (state_q == ST_RUN) && (!x_valid_q || bus.x_ready);
  assign q_accept = q_ready && bus.q_valid;
  assign x_take   = x_valid_q && bus.x_ready;

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case
    // leaves a signal unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    x_digit_d = x_digit_q;
    x_valid_d = x_valid_q;
    x_last_d  = x_last_q;
    done_d    = 1'b0;
`ifdef X400_MOD_4051_CHECK_EN
    err_d     = err_q;
`endif

    if (x_take) x_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          carry_d  = bus.r_in;
          cnt_d    = '0;
          x_last_d = 1'b0;
          state_d  = ST_RUN;
`ifdef X400_MOD_4051_CHECK_EN
          err_d    = (bus.r_in >= MODULUS_D);
`endif
        end
      end
      ST_RUN: begin
        if (q_accept) begin
          x_digit_d = mac_digit;
          carry_d   = mac_carry;
          x_valid_d = 1'b1;
          x_last_d  = (cnt_q == LAST_IDX);
          cnt_d     = cnt_q + cnt_t'(1);
          if (cnt_q == LAST_IDX) begin
            state_d = ST_DRAIN;
`ifdef X400_MOD_4051_CHECK_EN
            // X overflows 400 bits if the spare top bits or a final carry are set.
            if ((mac_digit[DIGIT_W-1 -: SPARE_W] != '0) || (mac_carry != '0))
              err_d = 1'b1;
`endif
          end
        end
      end
      ST_DRAIN: begin
        if (x_take) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      carry_q   <= '0;
      cnt_q     <= '0;
      x_digit_q <= '0;
      x_valid_q <= 1'b0;
      x_last_q  <= 1'b0;
      done_q    <= 1'b0;
`ifdef X400_MOD_4051_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      carry_q   <= carry_d;
      cnt_q     <= cnt_d;
      x_digit_q <= x_digit_d;
      x_valid_q <= x_valid_d;
      x_last_q  <= x_last_d;
      done_q    <= done_d;
`ifdef X400_MOD_4051_CHECK_EN
      err_q     <= err_d;
`endif
    end
  end

  assign bus.q_ready = q_ready;
  assign bus.x_valid = x_valid_q;
  assign bus.x_digit = x_digit_q;
  assign bus.x_last  = x_last_q;
  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.done    = done_q;
`ifdef X400_MOD_4051_CHECK_EN
  assign bus.err     = err_q;
`endif

endmodule

// File: tb/tb_x_400_mod_4051_lift.sv
// Directed self-checking bench for x_400_mod_4051_lift; also exercises the
// err checks when built with X400_MOD_4051_CHECK_EN.
module tb_x_400_mod_4051_lift;
  import mod_4051_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  x_400_mod_4051_lift_if bus ();

  x_400_mod_4051_lift dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_q_ready"}, 32'(bus.q_ready), 0);
    check({tag, "_x_valid"}, 32'(bus.x_valid), 0);
    check({tag, "_x_digit"}, 32'(bus.x_digit), 0);
    check({tag, "_x_last"},  32'(bus.x_last),  0);
    check({tag, "_busy"},    32'(bus.busy),    0);
    check({tag, "_done"},    32'(bus.done),    0);
`ifdef X400_MOD_4051_CHECK_EN
    check({tag, "_err"},     32'(bus.err),     0);
`endif
  endtask

  task automatic make_x(output logic [407:0] x);
    logic [415:0] tmp;
    for (int i = 0; i < 13; i++) tmp[i*32 +: 32] = $urandom;
    x = tmp[407:0];
    x[407:400] = '0;
  endtask

  // Streams Q with the given stall percentage and checks every presented
  // output digit against exp_x. abort_at >= 0 returns after that many outputs.
  task automatic run_op(input string tag, input digit_t r, input logic [407:0] q,
                        input logic [407:0] exp_x, input int gap, input int exp_done_at,
                        input int abort_at, input logic exp_err);
    int in_idx, out_idx, done_cnt, done_at, tail;
    in_idx = 0; out_idx = 0; done_cnt = 0; done_at = -1; tail = 0;

    @(negedge clk);
    bus.start   = 1'b1;
    bus.r_in    = r;
    bus.q_valid = 1'b0;
    bus.x_ready = 1'b0;

    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check({tag, "_busy_run"}, 32'(bus.busy), 1);
`ifdef X400_MOD_4051_CHECK_EN
        check({tag, "_err_at_start"}, 32'(bus.err), 32'(r >= 12'd4051));
`endif
      end
      if (bus.x_valid) begin
        check({tag, "_no_extra_out"}, 32'(out_idx < N_DIGITS), 1);
        if (out_idx < N_DIGITS) begin
          check($sformatf("%s_digit%0d", tag, out_idx), 32'(bus.x_digit),
                32'(exp_x[out_idx*12 +: 12]));
          check($sformatf("%s_last%0d", tag, out_idx), 32'(bus.x_last),
                32'(out_idx == N_DIGITS - 1));
        end
      end
      if (bus.done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (out_idx == N_DIGITS) begin
        tail++;
        if (tail > 3) break;
      end
      if (abort_at >= 0 && out_idx >= abort_at) begin
        bus.start = 1'b0; bus.q_valid = 1'b0; bus.x_ready = 1'b0;
        return;
      end

      // start is raised at random mid-operation; it must be ignored.
      bus.start   = (gap > 0 && out_idx < N_DIGITS) ? 1'($urandom_range(1)) : 1'b0;
      bus.r_in    = digit_t'($urandom);
      bus.q_valid = (in_idx < N_DIGITS) && ($urandom_range(99) >= gap);
      bus.q_digit = bus.q_valid ? q[in_idx*12 +: 12] : digit_t'($urandom);
      bus.x_ready = ($urandom_range(99) >= gap);
      #1;
      if (bus.x_valid && bus.x_ready) out_idx++;
      if (bus.q_valid && bus.q_ready) in_idx++;
    end

    bus.start = 1'b0; bus.q_valid = 1'b0;
    check({tag, "_outputs_taken"}, 32'(out_idx), 32'(N_DIGITS));
    check({tag, "_inputs_taken"},  32'(in_idx),  32'(N_DIGITS));
    check({tag, "_done_pulses"},   32'(done_cnt), 1);
    if (exp_done_at >= 0) check({tag, "_done_cycle"}, 32'(done_at), 32'(exp_done_at));
    check({tag, "_idle_busy"},    32'(bus.busy),    0);
    check({tag, "_idle_q_ready"}, 32'(bus.q_ready), 0);
`ifdef X400_MOD_4051_CHECK_EN
    check({tag, "_err_end"}, 32'(bus.err), 32'(exp_err));
`else
    if (exp_err) check({tag, "_err_unexpected_request"}, 0, 1);
`endif
  endtask

  initial begin
    logic [407:0] x_val;
    logic [407:0] q_val;
    digit_t       r_val;

    checks = 0; failures = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.r_in = '0; bus.q_valid = 1'b0;
    bus.q_digit = '0; bus.x_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // done appears after the 36th edge counted from the start edge (k=35).
    run_op("r5_q0", 12'd5, '0, 408'h5, 0, 35, -1, 1'b0);
    run_op("r0_q1", 12'd0, 408'h1, 408'hFD3, 0, 35, -1, 1'b0);
    run_op("rfd2_qfff", 12'hFD2, 408'hFFF, 408'hFD2FFF, 0, 35, -1, 1'b0);

    make_x(x_val);
    r_val = digit_t'(x_val % 408'd4051);
    q_val = x_val / 408'd4051;
    run_op("rand_gaps", r_val, q_val, x_val, 35, -1, -1, 1'b0);

    make_x(x_val);
    r_val = digit_t'(x_val % 408'd4051);
    q_val = x_val / 408'd4051;
    run_op("abort", r_val, q_val, x_val, 20, -1, 10, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;

    make_x(x_val);
    r_val = digit_t'(x_val % 408'd4051);
    q_val = x_val / 408'd4051;
    run_op("after_reset", r_val, q_val, x_val, 25, -1, -1, 1'b0);

`ifdef X400_MOD_4051_CHECK_EN
    run_op("q33_ovf", 12'd0, 408'h1 << 396, 408'hFD3 << 396, 0, 35, -1, 1'b1);
    run_op("r_4051", 12'd4051, '0, 408'hFD3, 0, 35, -1, 1'b1);
    run_op("clean", 12'd5, '0, 408'h5, 0, 35, -1, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
